regfile_ctrl: RTL
=================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameter DATA_W, default 13, register/data width.
REQ-002 Parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 CMD_VALID  input  1  command offered.
REQ-006 CMD_READY  output  1  command accepted when CMD_VALID and CMD_READY are both high at a rising edge.
REQ-007 CMD_OP  input  3  opcode, encodings per REQ-016.
REQ-008 CMD_D / CMD_A / CMD_B  input  ADDR_W each  destination / source-A / source-B register.
REQ-009 CMD_IMM  input  DATA_W  immediate for LDI.
REQ-010 RP / RQ  output  ADDR_W each  register-file read addresses.
REQ-011 DATAP / DATAQ  input  DATA_W each  register-file read data, combinational from RP/RQ.
REQ-012 WA  output  ADDR_W  register-file write address.
REQ-013 LD_DATA  output  DATA_W  register-file write data.
REQ-014 WR  output  1  register-file write enable; write occurs at the edge ending the WR-high cycle.
REQ-015 RES_VALID  output  1; RES_DATA  output  DATA_W; RES_Z, RES_C  output  1 each  result pulse, value, zero flag, carry/borrow flag.

Function
REQ-016 Opcodes: 000 NOP; 001 MOV D<=A; 010 LDI D<=IMM; 011 ADD D<=A+B; 100 SUB D<=A-B; 101 MIN D<=unsigned min(A,B); 110 CMP flags from A-B, no write; 111 RD result=A, no write.
REQ-017 FSM states IDLE, READ, EXEC, WRITE; CMD_READY high only in IDLE.
REQ-018 IDLE: on accept, latch op/D/A/B/IMM; NOP -> IDLE with no outputs changed; LDI -> EXEC; all others -> READ.
REQ-019 READ: RP=latched A, RQ=latched B; DATAP/DATAQ captured into operand registers at the edge ending READ; -> EXEC.
REQ-020 EXEC: compute result and flags into registers; -> WRITE.
REQ-021 WRITE: one cycle; RES_VALID=1, RES_DATA/RES_Z/RES_C valid; WR=1, WA=latched D, LD_DATA=result for MOV/LDI/ADD/SUB/MIN; WR=0 for CMP/RD; -> IDLE.
REQ-022 Latency: command accepted at edge E; MOV/ADD/SUB/MIN/CMP/RD have WRITE in the 3rd cycle after E; LDI in the 2nd; next accept possible at the edge ending WRITE plus one (IDLE cycle).
REQ-023 Arithmetic modulo 2^DATA_W; ADD C = carry-out; SUB/CMP C = 1 when A<B unsigned (borrow); Z = 1 when the DATA_W-bit result is 0; MOV/LDI/MIN/RD C=0.
REQ-024 CMP RES_DATA = A-B modulo 2^DATA_W.
REQ-025 A=B permitted; D equal to A or B permitted (operands captured before write).
REQ-026 Back-to-back commands: a write by command N is visible to reads of command N+1 (write completes before N+1 is accepted).
REQ-027 WR, RES_VALID low in every state except WRITE; RP/RQ/WA/LD_DATA hold last values when unused.
REQ-028 CMD_* ignored while CMD_READY low.

Reset
REQ-029 RST high at an edge -> state IDLE, CMD_READY=1, WR=0, RES_VALID=0, RES_DATA=0, RES_Z=0, RES_C=0, RP=RQ=WA=0, LD_DATA=0, latched command and operands cleared.
REQ-030 RST mid-operation aborts the command; no WR pulse after the reset edge; RST dominates CMD_VALID in the same cycle.

Structure
REQ-031 Shared package holds DATA_W, ADDR_W defaults, opcode constants, FSM state encoding.
REQ-032 One sub-module regfile_ctrl_alu: combinational op, A, B, IMM -> result, Z, C.
REQ-033 Top-level instantiates regfile_ctrl alongside the existing 8x13 register file; no storage of register contents inside regfile_ctrl.

Verification
REQ-034 LDI D=3 IMM=0x1A5 -> WR=1 WA=3 LD_DATA=0x1A5 two cycles after accept; RD A=3 then RES_DATA=0x1A5.
REQ-035 LDI r1=0x1FFF, LDI r2=1, ADD D=4 A=1 B=2 -> LD_DATA=0, RES_Z=1, RES_C=1.
REQ-036 r1=5, r2=9: SUB D=0 A=1 B=2 -> 0x1FFC, C=1; MIN D=5 -> 5; CMP -> WR=0, C=1, Z=0.
REQ-037 ADD D=1 A=1 B=1 with r1=7 -> r1=14; next RD A=1 returns 14 (back-to-back visibility).
REQ-038 RST asserted during READ of an ADD -> no WR pulse, CMD_READY=1 next cycle, all outputs at reset values.
REQ-039 CMD_VALID held high continuously with 4 commands -> exactly 4 accepts, CMD_READY low during READ/EXEC/WRITE, NOP produces no RES_VALID.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file controller: widths, opcodes and FSM states.
package regfile_ctrl_pkg;

   localparam int DATA_W_DFLT = 13;
   localparam int ADDR_W_DFLT = 3;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_MOV = 3'b001;
   localparam logic [2:0] OP_LDI = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_MIN = 3'b101;
   localparam logic [2:0] OP_CMP = 3'b110;
   localparam logic [2:0] OP_RD  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_e;

   // Opcodes whose result is written back to the destination register.
   function automatic logic op_writes(input logic [2:0] op);
      return op inside {OP_MOV, OP_LDI, OP_ADD, OP_SUB, OP_MIN};
   endfunction

endpackage

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU: result plus zero and carry/borrow flags for one opcode.
module regfile_ctrl_alu
   import regfile_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] imm_i,
   output logic [DATA_W-1:0] res_o,
   output logic              z_o,
   output logic              c_o
);

   // One extra bit holds carry-out for ADD and borrow for SUB/CMP.
   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   assign diff = {1'b0, a_i} - {1'b0, b_i};

   always_comb begin
      res_o = '0;
      c_o   = 1'b0;
      unique case (op_i)
         OP_MOV:         res_o = a_i;
         OP_LDI:         res_o = imm_i;
         OP_ADD: begin
            res_o = sum[DATA_W-1:0];
            c_o   = sum[DATA_W];
         end
         OP_SUB, OP_CMP: begin
            res_o = diff[DATA_W-1:0];
            c_o   = diff[DATA_W];
         end
         OP_MIN:         res_o = (a_i < b_i) ? a_i : b_i;
         OP_RD:          res_o = a_i;
         default:        res_o = '0;
      endcase
      z_o = (res_o == '0);
   end

endmodule

// File: rtl/regfile_ctrl.sv
// Sequences one command at a time through an external register file:
// IDLE -> (READ) -> EXEC -> WRITE, with operands captured before any write-back.
module regfile_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int ADDR_W = ADDR_W_DFLT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [2:0]        CMD_OP,
   input  logic [ADDR_W-1:0] CMD_D,
   input  logic [ADDR_W-1:0] CMD_A,
   input  logic [ADDR_W-1:0] CMD_B,
   input  logic [DATA_W-1:0] CMD_IMM,
   output logic [ADDR_W-1:0] RP,
   output logic [ADDR_W-1:0] RQ,
   input  logic [DATA_W-1:0] DATAP,
   input  logic [DATA_W-1:0] DATAQ,
   output logic [ADDR_W-1:0] WA,
   output logic [DATA_W-1:0] LD_DATA,
   output logic              WR,
   output logic              RES_VALID,
   output logic [DATA_W-1:0] RES_DATA,
   output logic              RES_Z,
   output logic              RES_C
);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] d_q, d_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [ADDR_W-1:0] rp_q, rp_d, rq_q, rq_d;
   logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [DATA_W-1:0] ld_q, ld_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              z_q, z_d, c_q, c_d;

   logic [DATA_W-1:0] alu_res;
   logic              alu_z, alu_c;

   regfile_ctrl_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i  (op_q),
      .a_i   (opa_q),
      .b_i   (opb_q),
      .imm_i (imm_q),
      .res_o (alu_res),
      .z_o   (alu_z),
      .c_o   (alu_c)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      d_d     = d_q;
      imm_d   = imm_q;
      rp_d    = rp_q;
      rq_d    = rq_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      wa_d    = wa_q;
      ld_d    = ld_q;
      res_d   = res_q;
      z_d     = z_q;
      c_d     = c_q;
      unique case (state_q)
         S_IDLE: begin
            if (CMD_VALID) begin
               op_d  = CMD_OP;
               d_d   = CMD_D;
               imm_d = CMD_IMM;
               if (CMD_OP == OP_LDI) begin
                  state_d = S_EXEC;
               end else if (CMD_OP != OP_NOP) begin
                  // RP/RQ double as the latched source addresses.
                  rp_d    = CMD_A;
                  rq_d    = CMD_B;
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            opa_d   = DATAP;
            opb_d   = DATAQ;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d = alu_res;
            z_d   = alu_z;
            c_d   = alu_c;
            if (op_writes(op_q)) begin
               wa_d = d_q;
               ld_d = alu_res;
            end
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         d_q     <= '0;
         imm_q   <= '0;
         rp_q    <= '0;
         rq_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         wa_q    <= '0;
         ld_q    <= '0;
         res_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         d_q     <= d_d;
         imm_q   <= imm_d;
         rp_q    <= rp_d;
         rq_q    <= rq_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         wa_q    <= wa_d;
         ld_q    <= ld_d;
         res_q   <= res_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   assign CMD_READY = (state_q == S_IDLE);
   assign RES_VALID = (state_q == S_WRITE);
   assign WR        = (state_q == S_WRITE) && op_writes(op_q);
   assign RP        = rp_q;
   assign RQ        = rq_q;
   assign WA        = wa_q;
   assign LD_DATA   = ld_q;
   assign RES_DATA  = res_q;
   assign RES_Z     = z_q;
   assign RES_C     = c_q;

endmodule
